// File: rtl/vecmac_pkg.sv
// Shared constants and beat-tag payload for the vector MAC engine.
package vecmac_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned BUS_W     = 32;
  localparam int unsigned PROD_W    = 16;
  localparam int unsigned TERM_W    = 18;
  localparam int unsigned ACC_W     = 32;
  localparam int unsigned LANES_MAX = BUS_W / DATA_W;

  typedef struct packed {
    logic              first;
    logic              last;
    logic [TERM_W-1:0] term;
  } beat_tag_t;

endpackage

// File: rtl/vector_mac_top_if.sv
// Vector beat input and scalar result output bundle of the vector MAC.
interface vector_mac_top_if;
  import vecmac_pkg::*;

  logic             vec_valid;
  logic [BUS_W-1:0] vec_a;
  logic [BUS_W-1:0] vec_b;
  logic             result_valid;
  logic [ACC_W-1:0] result_sum;

  modport master (
    output vec_valid, vec_a, vec_b,
    input  result_valid, result_sum
  );

  modport slave (
    input  vec_valid, vec_a, vec_b,
    output result_valid, result_sum
  );
endinterface

// File: rtl/vecmac_lane_dot.sv
// Combinational masked sum of up to four unsigned byte-lane products.
module vecmac_lane_dot
  import vecmac_pkg::*;
#(
  parameter int unsigned ACTIVE_LANES = 1
) (
  input  logic [BUS_W-1:0]     vec_a,
  input  logic [BUS_W-1:0]     vec_b,
  input  logic [LANES_MAX-1:0] lane_mask,
  output logic [TERM_W-1:0]    term_c
);

  // Single-lane builds only ever see byte lane 0.
  localparam logic [LANES_MAX-1:0] LANE_EN = (ACTIVE_LANES == 4) ? 4'hF : 4'h1;

  logic [LANES_MAX-1:0] lane_on;
  logic [PROD_W-1:0]    prod [LANES_MAX];

  assign lane_on = LANE_EN & lane_mask;

  always_comb begin
    term_c = '0;
    for (int i = 0; i < LANES_MAX; i++) begin
      prod[i] = PROD_W'(vec_a[DATA_W*i +: DATA_W]) * PROD_W'(vec_b[DATA_W*i +: DATA_W]);
      if (lane_on[i]) term_c = term_c + TERM_W'(prod[i]);
    end
  end

endmodule

// File: rtl/vector_mac_top.sv
// Unsigned INT8 dot-product engine: 3-stage beat/accumulate/result pipeline.
// Optional VECMAC_SATURATE_EN clamps the accumulator at all-ones instead of wrapping.
module vector_mac_top
  import vecmac_pkg::*;
#(
  parameter int unsigned ELEMS        = 1000,
  parameter int unsigned ACTIVE_LANES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  vector_mac_top_if.slave  bus
);

  localparam int unsigned BEATS = (ELEMS + ACTIVE_LANES - 1) / ACTIVE_LANES;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned REM   = ELEMS % ACTIVE_LANES;
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic [LANES_MAX-1:0] LAST_MASK =
    (REM == 0) ? 4'hF : LANES_MAX'((1 << REM) - 1);

  if ((ACTIVE_LANES != 1) && (ACTIVE_LANES != 4)) begin : g_bad_lanes
    $error("vector_mac_top: ACTIVE_LANES must be 1 or 4");
  end
  if (ELEMS < 1) begin : g_bad_elems
    $error("vector_mac_top: ELEMS must be at least 1");
  end

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 is_first_c, is_last_c;
  logic [LANES_MAX-1:0] mask_c;
  logic [TERM_W-1:0]    term_c;
  beat_tag_t            s1_q, s1_d;
  logic                 s1_vld_q;
  logic [ACC_W-1:0]     acc_q, acc_d, acc_add_c;
  logic                 s2_last_q;

  assign is_first_c = (cnt_q == '0);
  assign is_last_c  = (cnt_q == CNT_W'(BEATS - 1));
  assign mask_c     = is_last_c ? LAST_MASK : 4'hF;

  vecmac_lane_dot #(.ACTIVE_LANES(ACTIVE_LANES)) u_lane_dot (
    .vec_a     (bus.vec_a),
    .vec_b     (bus.vec_b),
    .lane_mask (mask_c),
    .term_c    (term_c)
  );

  // Beat counter and stage-1 tag capture.
  always_comb begin
    cnt_d = cnt_q;
    s1_d  = '{first: is_first_c, last: is_last_c, term: term_c};
    if (bus.vec_valid) cnt_d = is_last_c ? '0 : cnt_q + CNT_W'(1);
  end

`ifdef VECMAC_SATURATE_EN
  logic [SUM_W-1:0] sum_wide_c;
  assign sum_wide_c = SUM_W'(acc_q) + SUM_W'(s1_q.term);
  // Once at all-ones every further add carries, so the clamp holds until a first beat.
  assign acc_add_c  = sum_wide_c[ACC_W] ? '1 : sum_wide_c[ACC_W-1:0];
`else
  assign acc_add_c  = acc_q + ACC_W'(s1_q.term);
`endif

  // A first beat loads rather than adds, so vectors can run back to back.
  always_comb begin
    acc_d = acc_q;
    if (s1_vld_q) acc_d = s1_q.first ? ACC_W'(s1_q.term) : acc_add_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q            <= '0;
      s1_q             <= '0;
      s1_vld_q         <= 1'b0;
      acc_q            <= '0;
      s2_last_q        <= 1'b0;
      bus.result_valid <= 1'b0;
      bus.result_sum   <= '0;
    end else begin
      cnt_q            <= cnt_d;
      s1_vld_q         <= bus.vec_valid;
      if (bus.vec_valid) s1_q <= s1_d;
      acc_q            <= acc_d;
      s2_last_q        <= s1_vld_q & s1_q.last;
      bus.result_valid <= s2_last_q;
      // acc_q still holds the finished sum here even if the next vector just started.
      if (s2_last_q) bus.result_sum <= acc_q;
    end
  end

endmodule

// File: tb/tb_vector_mac_top.sv
// Directed bench for vector_mac_top across four parameterisations.
module tb_vector_mac_top;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc   = 0;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vector_mac_top_if if_l1 ();
  vector_mac_top_if if_l4 ();
  vector_mac_top_if if_bb ();
  vector_mac_top_if if_pt ();

  vector_mac_top #(.ELEMS(1000), .ACTIVE_LANES(1)) u_l1 (.clk(clk), .rst_n(rst_n), .bus(if_l1));
  vector_mac_top #(.ELEMS(1000), .ACTIVE_LANES(4)) u_l4 (.clk(clk), .rst_n(rst_n), .bus(if_l4));
  vector_mac_top #(.ELEMS(8),    .ACTIVE_LANES(4)) u_bb (.clk(clk), .rst_n(rst_n), .bus(if_bb));
  vector_mac_top #(.ELEMS(6),    .ACTIVE_LANES(4)) u_pt (.clk(clk), .rst_n(rst_n), .bus(if_pt));

  logic [31:0] sum_q [4][$];
  int unsigned cyc_q [4][$];

  always @(negedge clk) if (if_l1.result_valid === 1'b1) begin sum_q[0].push_back(if_l1.result_sum); cyc_q[0].push_back(cyc); end
  always @(negedge clk) if (if_l4.result_valid === 1'b1) begin sum_q[1].push_back(if_l4.result_sum); cyc_q[1].push_back(cyc); end
  always @(negedge clk) if (if_bb.result_valid === 1'b1) begin sum_q[2].push_back(if_bb.result_sum); cyc_q[2].push_back(cyc); end
  always @(negedge clk) if (if_pt.result_valid === 1'b1) begin sum_q[3].push_back(if_pt.result_sum); cyc_q[3].push_back(cyc); end

  function automatic logic [31:0] sum_at(input int k, input int i);
    if (i < sum_q[k].size()) return sum_q[k][i];
    return 'x;
  endfunction

  function automatic logic [31:0] cyc_at(input int k, input int i);
    if (i < cyc_q[k].size()) return 32'(cyc_q[k][i]);
    return 'x;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drv(input int k, input logic v, input logic [31:0] a, input logic [31:0] b);
    case (k)
      0: begin if_l1.vec_valid = v; if_l1.vec_a = a; if_l1.vec_b = b; end
      1: begin if_l4.vec_valid = v; if_l4.vec_a = a; if_l4.vec_b = b; end
      2: begin if_bb.vec_valid = v; if_bb.vec_a = a; if_bb.vec_b = b; end
      default: begin if_pt.vec_valid = v; if_pt.vec_a = a; if_pt.vec_b = b; end
    endcase
  endtask

  task automatic beat(input int k, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    drv(k, 1'b1, a, b);
  endtask

  task automatic idle(input int k, input int n);
    repeat (n) begin
      @(negedge clk);
      drv(k, 1'b0, 32'h0, 32'h0);
    end
  endtask

  function automatic logic [31:0] dot4(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s = 0;
    for (int j = 0; j < 4; j++) s += 32'(a[8*j +: 8]) * 32'(b[8*j +: 8]);
    return s;
  endfunction

  initial begin
    logic [31:0] a, b, exp_sum;
    int unsigned last_cyc;

    for (int k = 0; k < 4; k++) drv(k, 1'b0, 32'h0, 32'h0);

    // Reset then idle
    repeat (4) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_valid_l1", 32'(if_l1.result_valid), 32'd0);
    check("rst_sum_l1",   if_l1.result_sum, 32'd0);
    check("rst_valid_l4", 32'(if_l4.result_valid), 32'd0);
    check("rst_sum_l4",   if_l4.result_sum, 32'd0);
    check("rst_valid_bb", 32'(if_bb.result_valid), 32'd0);
    check("rst_sum_bb",   if_bb.result_sum, 32'd0);
    check("rst_valid_pt", 32'(if_pt.result_valid), 32'd0);
    check("rst_sum_pt",   if_pt.result_sum, 32'd0);
    check("rst_pulses_all", 32'(sum_q[0].size() + sum_q[1].size() + sum_q[2].size() + sum_q[3].size()), 32'd0);

    // One lane, 1000 random beats with idle gaps; upper bytes must be ignored
    exp_sum  = 0;
    last_cyc = 0;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom;
      beat(0, a, b);
      exp_sum += 32'(a[7:0]) * 32'(b[7:0]);
      if (i == 999) last_cyc = cyc;
      idle(0, 1);
    end
    idle(0, 8);
    check("l1_pulses",  32'(sum_q[0].size()), 32'd1);
    check("l1_sum",     sum_at(0, 0), exp_sum);
    check("l1_latency", cyc_at(0, 0), 32'(last_cyc + 3));

    // Four lanes, 250 random beats back to back
    exp_sum = 0;
    for (int i = 0; i < 250; i++) begin
      a = $urandom;
      b = $urandom;
      beat(1, a, b);
      exp_sum += dot4(a, b);
    end
    idle(1, 8);
    check("l4_rand_pulses", 32'(sum_q[1].size()), 32'd1);
    check("l4_rand_sum",    sum_at(1, 0), exp_sum);
    sum_q[1].delete();
    cyc_q[1].delete();

    // Four lanes, all-ones bytes: 250 * 4 * 255 * 255
    for (int i = 0; i < 250; i++) beat(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle(1, 8);
    check("l4_max_pulses", 32'(sum_q[1].size()), 32'd1);
    check("l4_max_sum",    sum_at(1, 0), 32'(250 * 4 * 65025));
    sum_q[1].delete();
    cyc_q[1].delete();

    // Back-to-back 8-element vectors with continuous valid
    beat(2, 32'h0101_0101, 32'h0101_0101);
    beat(2, 32'h0101_0101, 32'h0101_0101);
    beat(2, 32'h0202_0202, 32'h0202_0202);
    beat(2, 32'h0202_0202, 32'h0202_0202);
    idle(2, 8);
    check("bb_pulses", 32'(sum_q[2].size()), 32'd2);
    check("bb_sum0",   sum_at(2, 0), 32'd8);
    check("bb_sum1",   sum_at(2, 1), 32'd32);
    check("bb_gap",    cyc_at(2, 1) - cyc_at(2, 0), 32'd2);

    // ELEMS=6 on four lanes: lanes 2-3 of the second beat are masked
    beat(3, 32'h0101_0101, 32'h0101_0101);
    beat(3, 32'h0101_0101, 32'h0101_0101);
    idle(3, 3);
    beat(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    beat(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle(3, 8);
    check("pt_pulses", 32'(sum_q[3].size()), 32'd2);
    check("pt_sum_ones", sum_at(3, 0), 32'd6);
    check("pt_sum_max",  sum_at(3, 1), 32'(6 * 65025));

    // Reset in the middle of a vector discards it
    for (int k = 0; k < 4; k++) begin sum_q[k].delete(); cyc_q[k].delete(); end
    for (int i = 0; i < 100; i++) beat(1, 32'h0101_0101, 32'h0101_0101);
    idle(1, 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(1, 2);
    check("abort_no_pulse", 32'(sum_q[1].size()), 32'd0);
    for (int i = 0; i < 250; i++) beat(1, 32'h0101_0101, 32'h0101_0101);
    idle(1, 8);
    check("abort_pulses", 32'(sum_q[1].size()), 32'd1);
    check("abort_sum",    sum_at(1, 0), 32'd1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
